i2c_slave_phy: RTL and testbench

- Bus front end for the TMP10X I2C slave, sitting directly upstream of the slave control/memory stage.
- Oversamples raw SCL/SDA on the system clock, synchronises and deglitches them, and detects START/STOP.
- Deserialises the address and write bytes, serialises the read bytes, and drives the ACK/data-low enable for the open-drain SDA pad.
- Downstream logic sees only byte-level strobes.

---
 rtl/i2c_slave_phy.sv | 233 +++++++++++++++++++++++
 tb/tb_i2c_slave_phy.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_phy.sv
// I2C slave bus front end: pad synchronisation and deglitching, START/STOP
// detection, and bit-level shifting of address, write and read bytes.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | bus free or not yet addressed
// ADDR      | shifting in the address byte; pend = matched, waiting for SCL fall
// ADDR_ACK  | driving the address ACK low
// RX        | shifting in a write byte; pend = ACK pending on the next SCL fall
// RX_ACK    | driving the write-byte ACK low
// TX        | shifting out a read byte
// TX_ACK    | SDA released for the master ACK; pend = ACK seen, reload on fall
// WAIT_STOP | not addressed or NACKed; only START/STOP leave this state

module i2c_slave_phy #(
  parameter int FILTER_LEN    = 3,
  parameter int ADDRESSLENGTH = 7
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     scl_in,
  input  logic                     sda_in,
  output logic                     sda_oe,
  input  logic [ADDRESSLENGTH-1:0] own_addr,
  input  logic                     ack_en,
  input  logic [7:0]               tx_data,
  output logic                     start_det,
  output logic                     stop_det,
  output logic                     byte_valid,
  output logic                     byte_is_addr,
  output logic [7:0]               rx_byte,
  output logic                     rw,
  output logic                     tx_req,
  output logic                     busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX, RX_ACK, TX, TX_ACK, WAIT_STOP
  } state_t;

  localparam logic [3:0] FCMP = 4'(FILTER_LEN - 1);

  // index 0 carries SCL, index 1 carries SDA
  logic [1:0]      sync1, sync2, filt, filt_d;
  logic [1:0][3:0] fcnt;

  state_t     state;
  logic [7:0] shreg;
  logic [2:0] bit_cnt;
  logic       pend;

  logic       scl_rise, scl_fall, start_ev, stop_ev, addr_match;
  logic [7:0] rx_next;

  // Two-flop synchroniser, then a run-length filter: a line only changes
  // after FILTER_LEN consecutive samples disagree with its current level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= '1;
      sync2  <= '1;
      filt   <= '1;
      filt_d <= '1;
      fcnt   <= '0;
    end else begin
      sync1  <= {sda_in, scl_in};
      sync2  <= sync1;
      filt_d <= filt;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != filt[i]) begin
          if (fcnt[i] == FCMP) begin
            filt[i] <= sync2[i];
            fcnt[i] <= '0;
          end else begin
            fcnt[i] <= fcnt[i] + 4'd1;
          end
        end else begin
          fcnt[i] <= '0;
        end
      end
    end
  end

  // Bus events from the filtered lines; SCL must be high on both samples
  // for an SDA edge to count as START/STOP.
  always_comb begin
    scl_rise   = filt[0] & ~filt_d[0];
    scl_fall   = ~filt[0] & filt_d[0];
    start_ev   = filt[0] & filt_d[0] & filt_d[1] & ~filt[1];
    stop_ev    = filt[0] & filt_d[0] & ~filt_d[1] & filt[1];
    rx_next    = {shreg[6:0], filt[1]};
    addr_match = (shreg[6:0] == own_addr);
  end

  // Protocol FSM; STOP outranks START, both outrank any bit activity.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      pend         <= 1'b0;
      sda_oe       <= 1'b0;
      start_det    <= 1'b0;
      stop_det     <= 1'b0;
      byte_valid   <= 1'b0;
      byte_is_addr <= 1'b0;
      rx_byte      <= '0;
      rw           <= 1'b0;
      tx_req       <= 1'b0;
      busy         <= 1'b0;
    end else begin
      start_det  <= 1'b0;
      stop_det   <= 1'b0;
      byte_valid <= 1'b0;
      tx_req     <= 1'b0;
      if (stop_ev) begin
        state    <= IDLE;
        sda_oe   <= 1'b0;
        busy     <= 1'b0;
        pend     <= 1'b0;
        stop_det <= 1'b1;
      end else if (start_ev) begin
        state     <= ADDR;
        bit_cnt   <= '0;
        sda_oe    <= 1'b0;
        pend      <= 1'b0;
        start_det <= 1'b1;
      end else begin
        unique case (state)
          IDLE: ;
          ADDR: begin
            if (pend) begin
              if (scl_fall) begin
                sda_oe <= 1'b1;
                pend   <= 1'b0;
                state  <= ADDR_ACK;
              end
            end else if (scl_rise) begin
              shreg   <= rx_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_byte      <= rx_next;
                byte_valid   <= 1'b1;
                byte_is_addr <= 1'b1;
                if (addr_match) begin
                  rw   <= filt[1];
                  busy <= 1'b1;
                  pend <= 1'b1;
                end else begin
                  busy  <= 1'b0;
                  state <= WAIT_STOP;
                end
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt <= '0;
              if (rw) begin
                tx_req <= 1'b1;
                shreg  <= tx_data;
                sda_oe <= ~tx_data[7];
                state  <= TX;
              end else begin
                sda_oe <= 1'b0;
                state  <= RX;
              end
            end
          end
          RX: begin
            if (pend) begin
              if (scl_fall) begin
                sda_oe <= 1'b1;
                pend   <= 1'b0;
                state  <= RX_ACK;
              end
            end else if (scl_rise) begin
              shreg   <= rx_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_byte      <= rx_next;
                byte_valid   <= 1'b1;
                byte_is_addr <= 1'b0;
                if (ack_en) pend <= 1'b1;
                else        state <= WAIT_STOP;
              end
            end
          end
          RX_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= '0;
              state   <= RX;
            end
          end
          TX: begin
            if (scl_fall) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                sda_oe <= 1'b0;
                state  <= TX_ACK;
              end else begin
                shreg  <= {shreg[6:0], 1'b0};
                sda_oe <= ~shreg[6];
              end
            end
          end
          TX_ACK: begin
            if (pend) begin
              if (scl_fall) begin
                tx_req  <= 1'b1;
                shreg   <= tx_data;
                sda_oe  <= ~tx_data[7];
                bit_cnt <= '0;
                pend    <= 1'b0;
                state   <= TX;
              end
            end else if (scl_rise) begin
              if (filt[1]) begin
                busy  <= 1'b0;
                state <= WAIT_STOP;
              end else begin
                pend <= 1'b1;
              end
            end
          end
          WAIT_STOP: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_phy.sv
// Bench for i2c_slave_phy: a bit-banged I2C master drives the pads through a
// wired-AND SDA; expected byte-level events go into a queue that a monitor
// drains whenever the DUT pulses one of its strobes.

module tb_i2c_slave_phy;

  localparam int Q = 8;  // quarter SCL period in clk cycles

  localparam logic [2:0] EV_START = 3'd1;
  localparam logic [2:0] EV_STOP  = 3'd2;
  localparam logic [2:0] EV_BYTE  = 3'd3;
  localparam logic [2:0] EV_TXREQ = 3'd4;

  typedef struct packed {
    logic [2:0] kind;
    logic [8:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic [6:0] own_addr = 7'h48;
  logic       ack_en = 1'b1;
  logic [7:0] tx_data = 8'h00;

  logic       sda_line;
  logic       sda_oe, start_det, stop_det, byte_valid, byte_is_addr, rw, tx_req, busy;
  logic [7:0] rx_byte;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass = 0;
  int  oe_cnt = 0;

  assign sda_line = sda_m & ~sda_oe;

  i2c_slave_phy #(.FILTER_LEN(3), .ADDRESSLENGTH(7)) dut (
    .clk(clk), .reset(reset), .scl_in(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .own_addr(own_addr), .ack_en(ack_en), .tx_data(tx_data),
    .start_det(start_det), .stop_det(stop_det), .byte_valid(byte_valid),
    .byte_is_addr(byte_is_addr), .rx_byte(rx_byte), .rw(rw), .tx_req(tx_req),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic expect_ev(input logic [2:0] kind, input logic [8:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic compare_ev(input ev_t got);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got %h, expected no event", got);
    end else begin
      e = exp_q.pop_front();
      check("event", 16'(got), 16'(e));
    end
  endtask

  // Monitor: every strobe the DUT emits is matched against the queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (sda_oe) oe_cnt++;
      if (start_det)  compare_ev({EV_START, 9'd0});
      if (stop_det)   compare_ev({EV_STOP, 9'd0});
      if (byte_valid) compare_ev({EV_BYTE, byte_is_addr, rx_byte});
      if (tx_req)     compare_ev({EV_TXREQ, 9'd0});
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL period starting and ending with SCL low; s is the line at mid-high.
  task automatic clk_bit(input logic b, input logic g, output logic s);
    wait_clk(Q);
    sda_m = b;
    if (g) begin
      wait_clk(2); scl = 1'b1; wait_clk(2); scl = 1'b0; wait_clk(Q - 4);
    end else begin
      wait_clk(Q);
    end
    scl = 1'b1;
    wait_clk(Q);
    s = sda_line;
    if (g) begin
      sda_m = ~b; wait_clk(2); sda_m = b; wait_clk(Q - 2);
    end else begin
      wait_clk(Q);
    end
    scl = 1'b0;
  endtask

  task automatic start_cond();
    if (scl) begin
      sda_m = 1'b1;
    end else begin
      wait_clk(Q); sda_m = 1'b1; wait_clk(Q); scl = 1'b1;
    end
    wait_clk(Q); sda_m = 1'b0; wait_clk(Q); scl = 1'b0;
  endtask

  task automatic stop_cond();
    if (scl) begin
      wait_clk(Q); scl = 1'b0;
    end
    wait_clk(Q); sda_m = 1'b0; wait_clk(Q); scl = 1'b1;
    wait_clk(Q); sda_m = 1'b1; wait_clk(2 * Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, input logic [7:0] gmask, input logic exp_ack,
                         input string nm);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], gmask[i], s);
    clk_bit(1'b1, 1'b0, s);
    check({nm, "_ack"}, 16'(s), exp_ack ? 16'd0 : 16'd1);
  endtask

  task automatic rd_byte(input logic mack, input logic [7:0] next_tx, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, 1'b0, s);
      d[i] = s;
    end
    tx_data = next_tx;
    clk_bit(~mack, 1'b0, s);
  endtask

  function automatic logic [15:0] all_outs();
    return {sda_oe, start_det, stop_det, byte_valid, byte_is_addr, rw, tx_req, busy, rx_byte};
  endfunction

  initial begin
    logic [7:0] d;
    logic       s;
    int         oe0;

    wait_clk(4);
    reset = 1'b0;
    wait_clk(100);
    check("idle_outputs", all_outs(), 16'h0000);

    // write 0x90 (own 0x48), data 0x5A
    expect_ev(EV_START, 9'd0);
    expect_ev(EV_BYTE, {1'b1, 8'h90});
    expect_ev(EV_BYTE, {1'b0, 8'h5A});
    expect_ev(EV_STOP, 9'd0);
    start_cond();
    wr_byte(8'h90, 8'h00, 1'b1, "w_addr");
    check("w_busy", 16'(busy), 16'd1);
    check("w_rw", 16'(rw), 16'd0);
    wr_byte(8'h5A, 8'h00, 1'b1, "w_data");
    stop_cond();
    check("w_busy_end", 16'(busy), 16'd0);

    // foreign address 0x49: NACK, following byte ignored
    oe0 = oe_cnt;
    expect_ev(EV_START, 9'd0);
    expect_ev(EV_BYTE, {1'b1, 8'h92});
    expect_ev(EV_STOP, 9'd0);
    start_cond();
    wr_byte(8'h92, 8'h00, 1'b0, "n_addr");
    check("n_busy", 16'(busy), 16'd0);
    wr_byte(8'h11, 8'h00, 1'b0, "n_more");
    stop_cond();
    check("n_no_drive", 16'(oe_cnt - oe0), 16'd0);

    // read 0x91: 0xC3 (master ACK) then 0x0F (master NACK)
    tx_data = 8'hC3;
    expect_ev(EV_START, 9'd0);
    expect_ev(EV_BYTE, {1'b1, 8'h91});
    expect_ev(EV_TXREQ, 9'd0);
    expect_ev(EV_TXREQ, 9'd0);
    expect_ev(EV_STOP, 9'd0);
    start_cond();
    wr_byte(8'h91, 8'h00, 1'b1, "r_addr");
    check("r_rw", 16'(rw), 16'd1);
    check("r_busy", 16'(busy), 16'd1);
    rd_byte(1'b1, 8'h0F, d);
    check("r_byte0", 16'(d), 16'h00C3);
    rd_byte(1'b0, 8'h00, d);
    check("r_byte1", 16'(d), 16'h000F);
    wait_clk(Q);
    check("r_released", {15'd0, sda_oe} | {14'd0, busy, 1'b0}, 16'd0);
    stop_cond();

    // 2-clk glitches on SCL (low phase) and SDA (high phase, both polarities)
    expect_ev(EV_START, 9'd0);
    expect_ev(EV_BYTE, {1'b1, 8'h90});
    expect_ev(EV_BYTE, {1'b0, 8'hA5});
    expect_ev(EV_STOP, 9'd0);
    start_cond();
    wr_byte(8'h90, 8'h00, 1'b1, "g_addr");
    wr_byte(8'hA5, 8'b1100_0110, 1'b1, "g_data");
    stop_cond();
    check("g_rx_byte", 16'(rx_byte), 16'h00A5);

    // repeated START after 4 data bits, then reset during the read ACK
    expect_ev(EV_START, 9'd0);
    expect_ev(EV_BYTE, {1'b1, 8'h90});
    expect_ev(EV_START, 9'd0);
    expect_ev(EV_BYTE, {1'b1, 8'h91});
    start_cond();
    wr_byte(8'h90, 8'h00, 1'b1, "rs_addr");
    clk_bit(1'b1, 1'b0, s);
    clk_bit(1'b0, 1'b0, s);
    clk_bit(1'b1, 1'b0, s);
    clk_bit(1'b1, 1'b0, s);
    start_cond();
    d = 8'h91;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], 1'b0, s);
    wait_clk(Q); sda_m = 1'b1; wait_clk(Q); scl = 1'b1; wait_clk(Q);
    check("rs_ack_drive", 16'(sda_oe), 16'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rs_reset_outs", all_outs(), 16'h0000);
    wait_clk(2);
    reset = 1'b0;
    expect_ev(EV_STOP, 9'd0);
    stop_cond();

    wait_clk(20);
    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
